// File: rtl/operand2_shifter.sv
// -----------------------------------------------------------------------------
// operand2_shifter
//   Pipelined barrel-shifter stage in front of the ALU. Builds operand 2 and
//   the shifter carry-out from either a rotated 8-bit immediate or a shifted
//   register, and carries Rn and the ALU opcode alongside so the ALU bundle
//   leaves this stage registered and aligned.
//
//   Immediate and immediate-amount shifts complete in one cycle. Shifts whose
//   amount comes from Rs[7:0] spend one extra cycle in the REG state.
//
// Ports
//   in_Clk, in_Rst_N          clock (rising edge), async active-low reset
//   in_Valid / out_Ready      upstream handshake
//   in_Rn, in_Opcode          passed through to out_Rn / out_Opcode
//   in_Rm, in_Rs              shifted register, shift-amount register (Rs[7:0])
//   in_ImmMode, in_Imm8, in_Rot   rotated-immediate operand select and fields
//   in_ShiftType, in_ShiftImm, in_ShiftByReg   register-shift controls
//   in_CFlag                  current C flag (used for amount-zero/RRX cases)
//   out_Valid / in_Ready      downstream handshake
//   out_Op2, out_Carry        shifter result and carry-out
// -----------------------------------------------------------------------------
module operand2_shifter #(
    parameter int WordWidth = 32
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst_N,
    input  logic                 in_Valid,
    output logic                 out_Ready,
    input  logic [WordWidth-1:0] in_Rn,
    input  logic [WordWidth-1:0] in_Rm,
    input  logic [WordWidth-1:0] in_Rs,
    input  logic                 in_ImmMode,
    input  logic [7:0]           in_Imm8,
    input  logic [3:0]           in_Rot,
    input  logic [1:0]           in_ShiftType,
    input  logic [4:0]           in_ShiftImm,
    input  logic                 in_ShiftByReg,
    input  logic                 in_CFlag,
    input  logic [3:0]           in_Opcode,
    output logic                 out_Valid,
    input  logic                 in_Ready,
    output logic [WordWidth-1:0] out_Rn,
    output logic [WordWidth-1:0] out_Op2,
    output logic                 out_Carry,
    output logic [3:0]           out_Opcode
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REG  = 1'b1;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Rotate right by 0..31.
    function automatic logic [WordWidth-1:0] ror_w(input logic [WordWidth-1:0] x,
                                                   input logic [4:0]           amt);
        logic [2*WordWidth-1:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[WordWidth-1:0];
    endfunction

    // Shift by a non-zero amount (up to 255); returns {carry, op2}.
    // The extra bit next to Rm catches the last bit shifted out, which also
    // yields the amount==32 and amount>32 results for free.
    function automatic logic [WordWidth:0] shift_core(input logic [WordWidth-1:0] rm,
                                                      input logic [1:0]           stype,
                                                      input logic [7:0]           amt);
        logic [WordWidth:0]        t;
        logic [WordWidth-1:0]      r;
        logic [WordWidth:0]        res;
        t   = '0;
        r   = '0;
        res = {1'b0, rm};
        case (stype)
            SH_LSL: begin
                t   = {1'b0, rm} << amt;
                res = t;
            end
            SH_LSR: begin
                t   = {rm, 1'b0} >> amt;
                res = {t[0], t[WordWidth:1]};
            end
            SH_ASR: begin
                t   = $unsigned($signed({rm, 1'b0}) >>> amt);
                res = {t[0], t[WordWidth:1]};
            end
            SH_ROR: begin
                // A multiple of 32 leaves Rm unchanged with carry Rm[31].
                r   = ror_w(rm, amt[4:0]);
                res = {r[WordWidth-1], r};
            end
            default: res = {1'b0, rm};
        endcase
        return res;
    endfunction

    // Rotated 8-bit immediate; returns {carry, op2}.
    function automatic logic [WordWidth:0] imm_result(input logic [7:0] imm8,
                                                      input logic [3:0] rot,
                                                      input logic       cflag);
        logic [WordWidth-1:0] op;
        logic                 c;
        op = ror_w({{(WordWidth-8){1'b0}}, imm8}, {rot, 1'b0});
        if (rot == 4'd0) begin
            c = cflag;
        end else begin
            c = op[WordWidth-1];
        end
        return {c, op};
    endfunction

    // Immediate-amount shift: amount 0 encodes LSL#0, LSR#32, ASR#32, RRX.
    function automatic logic [WordWidth:0] immshift_result(input logic [WordWidth-1:0] rm,
                                                           input logic [1:0]           stype,
                                                           input logic [4:0]           n,
                                                           input logic                 cflag);
        logic [WordWidth:0] res;
        if (n == 5'd0) begin
            case (stype)
                SH_LSL:  res = {cflag, rm};
                SH_LSR:  res = shift_core(rm, stype, 8'd32);
                SH_ASR:  res = shift_core(rm, stype, 8'd32);
                SH_ROR:  res = {rm[0], cflag, rm[WordWidth-1:1]};
                default: res = {cflag, rm};
            endcase
        end else begin
            res = shift_core(rm, stype, {3'b000, n});
        end
        return res;
    endfunction

    // Register-amount shift: amount 0 passes Rm and the C flag through.
    function automatic logic [WordWidth:0] regshift_result(input logic [WordWidth-1:0] rm,
                                                           input logic [1:0]           stype,
                                                           input logic [7:0]           a,
                                                           input logic                 cflag);
        logic [WordWidth:0] res;
        if (a == 8'd0) begin
            res = {cflag, rm};
        end else begin
            res = shift_core(rm, stype, a);
        end
        return res;
    endfunction

    logic [0:0]           state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WordWidth-1:0] out_rn_q, out_rn_d;
    logic [WordWidth-1:0] out_op2_q, out_op2_d;
    logic                 out_carry_q, out_carry_d;
    logic [3:0]           out_opcode_q, out_opcode_d;

    // Operands held while a register-amount shift waits in REG.
    logic [WordWidth-1:0] cap_rn_q, cap_rm_q;
    logic [7:0]           cap_amt_q;
    logic [1:0]           cap_type_q;
    logic                 cap_cflag_q;
    logic [3:0]           cap_opcode_q;

    logic                 accept_s;
    logic                 reg_path_s;
    logic                 capture_s;
    logic                 load_s;
    logic [WordWidth:0]   res_s;

    // Rs above the bottom byte never affects the result.
    logic                 unused_rs_s;
    assign unused_rs_s = ^in_Rs[WordWidth-1:8];

    assign out_Ready  = (state_q == ST_IDLE) && (!out_valid_q || in_Ready);
    assign accept_s   = in_Valid && out_Ready;
    assign reg_path_s = !in_ImmMode && in_ShiftByReg;

    // Next-state, result selection and output-register update.
    always_comb begin
        state_d      = state_q;
        capture_s    = 1'b0;
        load_s       = 1'b0;
        res_s        = '0;
        out_rn_d     = out_rn_q;
        out_opcode_d = out_opcode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && reg_path_s) begin
                    capture_s = 1'b1;
                    state_d   = ST_REG;
                end else if (accept_s) begin
                    load_s       = 1'b1;
                    out_rn_d     = in_Rn;
                    out_opcode_d = in_Opcode;
                    if (in_ImmMode) begin
                        res_s = imm_result(in_Imm8, in_Rot, in_CFlag);
                    end else begin
                        res_s = immshift_result(in_Rm, in_ShiftType, in_ShiftImm, in_CFlag);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REG: begin
                if (!out_valid_q || in_Ready) begin
                    load_s       = 1'b1;
                    out_rn_d     = cap_rn_q;
                    out_opcode_d = cap_opcode_q;
                    res_s        = regshift_result(cap_rm_q, cap_type_q, cap_amt_q, cap_cflag_q);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REG;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_s) begin
            out_valid_d = 1'b1;
            out_op2_d   = res_s[WordWidth-1:0];
            out_carry_d = res_s[WordWidth];
        end else if (in_Ready) begin
            out_valid_d = 1'b0;
            out_op2_d   = out_op2_q;
            out_carry_d = out_carry_q;
        end else begin
            out_valid_d = out_valid_q;
            out_op2_d   = out_op2_q;
            out_carry_d = out_carry_q;
        end
    end

    // State and output bundle registers.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_rn_q     <= '0;
            out_op2_q    <= '0;
            out_carry_q  <= 1'b0;
            out_opcode_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_rn_q     <= out_rn_d;
            out_op2_q    <= out_op2_d;
            out_carry_q  <= out_carry_d;
            out_opcode_q <= out_opcode_d;
        end
    end

    // Operand capture for register-amount shifts.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            cap_rn_q     <= '0;
            cap_rm_q     <= '0;
            cap_amt_q    <= 8'd0;
            cap_type_q   <= 2'd0;
            cap_cflag_q  <= 1'b0;
            cap_opcode_q <= 4'd0;
        end else if (capture_s) begin
            cap_rn_q     <= in_Rn;
            cap_rm_q     <= in_Rm;
            cap_amt_q    <= in_Rs[7:0];
            cap_type_q   <= in_ShiftType;
            cap_cflag_q  <= in_CFlag;
            cap_opcode_q <= in_Opcode;
        end else begin
            cap_rn_q     <= cap_rn_q;
            cap_rm_q     <= cap_rm_q;
            cap_amt_q    <= cap_amt_q;
            cap_type_q   <= cap_type_q;
            cap_cflag_q  <= cap_cflag_q;
            cap_opcode_q <= cap_opcode_q;
        end
    end

    assign out_Valid  = out_valid_q;
    assign out_Rn     = out_rn_q;
    assign out_Op2    = out_op2_q;
    assign out_Carry  = out_carry_q;
    assign out_Opcode = out_opcode_q;

endmodule

// File: tb/tb_operand2_shifter.sv
// -----------------------------------------------------------------------------
// tb_operand2_shifter
//   Directed, table-driven bench for operand2_shifter: a vector table covers
//   immediate rotates, immediate-amount and register-amount shifts with their
//   special encodings; hand-written sequences cover backpressure, streaming
//   and reset during a register-amount shift.
// -----------------------------------------------------------------------------
module tb_operand2_shifter;

    typedef struct {
        logic        imm_mode;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [1:0]  stype;
        logic [4:0]  simm;
        logic        by_reg;
        logic        cflag;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] exp_op2;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    logic        in_Clk = 1'b0;
    logic        in_Rst_N = 1'b0;
    logic        in_Valid = 1'b0;
    logic        out_Ready;
    logic [31:0] in_Rn = 32'd0;
    logic [31:0] in_Rm = 32'd0;
    logic [31:0] in_Rs = 32'd0;
    logic        in_ImmMode = 1'b0;
    logic [7:0]  in_Imm8 = 8'd0;
    logic [3:0]  in_Rot = 4'd0;
    logic [1:0]  in_ShiftType = 2'd0;
    logic [4:0]  in_ShiftImm = 5'd0;
    logic        in_ShiftByReg = 1'b0;
    logic        in_CFlag = 1'b0;
    logic [3:0]  in_Opcode = 4'd0;
    logic        out_Valid;
    logic        in_Ready = 1'b1;
    logic [31:0] out_Rn;
    logic [31:0] out_Op2;
    logic        out_Carry;
    logic [3:0]  out_Opcode;

    int n_cmp = 0;
    int n_bad = 0;

    operand2_shifter #(.WordWidth(32)) dut (
        .in_Clk(in_Clk), .in_Rst_N(in_Rst_N), .in_Valid(in_Valid), .out_Ready(out_Ready),
        .in_Rn(in_Rn), .in_Rm(in_Rm), .in_Rs(in_Rs), .in_ImmMode(in_ImmMode),
        .in_Imm8(in_Imm8), .in_Rot(in_Rot), .in_ShiftType(in_ShiftType),
        .in_ShiftImm(in_ShiftImm), .in_ShiftByReg(in_ShiftByReg), .in_CFlag(in_CFlag),
        .in_Opcode(in_Opcode), .out_Valid(out_Valid), .in_Ready(in_Ready),
        .out_Rn(out_Rn), .out_Op2(out_Op2), .out_Carry(out_Carry), .out_Opcode(out_Opcode)
    );

    always #5 in_Clk = ~in_Clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic im, input logic [7:0] i8, input logic [3:0] rt,
                                input logic [1:0] st, input logic [4:0] si, input logic br,
                                input logic cf, input logic [31:0] rm, input logic [31:0] rs,
                                input logic [31:0] eo, input logic ec, input int el);
        vec_t v;
        v.imm_mode = im; v.imm8 = i8; v.rot = rt; v.stype = st; v.simm = si;
        v.by_reg = br; v.cflag = cf; v.rm = rm; v.rs = rs;
        v.exp_op2 = eo; v.exp_c = ec; v.exp_lat = el;
        return v;
    endfunction

    task automatic drive_imm(input logic [7:0] i8, input logic [3:0] rt,
                             input logic [31:0] rn, input logic [3:0] opc);
        in_ImmMode = 1'b1; in_Imm8 = i8; in_Rot = rt; in_ShiftByReg = 1'b0;
        in_CFlag = 1'b0; in_Rn = rn; in_Opcode = opc;
    endtask

    vec_t vecs[19];

    initial begin
        //               im    imm8   rot   type   simm   byreg cf    rm            rs            op2           c     lat
        vecs[0]  = mk(1'b1, 8'hFF, 4'd4, 2'b00, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        32'hFF000000, 1'b1, 1);
        vecs[1]  = mk(1'b1, 8'hFF, 4'd0, 2'b00, 5'd0,  1'b0, 1'b1, 32'h0,        32'h0,        32'h000000FF, 1'b1, 1);
        vecs[2]  = mk(1'b1, 8'h3F, 4'd1, 2'b00, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        32'hC000000F, 1'b1, 1);
        vecs[3]  = mk(1'b0, 8'h00, 4'd0, 2'b01, 5'd0,  1'b0, 1'b1, 32'h80000001, 32'h0,        32'h00000000, 1'b1, 1);
        vecs[4]  = mk(1'b0, 8'h00, 4'd0, 2'b10, 5'd0,  1'b0, 1'b1, 32'h80000001, 32'h0,        32'hFFFFFFFF, 1'b1, 1);
        vecs[5]  = mk(1'b0, 8'h00, 4'd0, 2'b11, 5'd0,  1'b0, 1'b1, 32'h80000001, 32'h0,        32'hC0000000, 1'b1, 1);
        vecs[6]  = mk(1'b0, 8'h00, 4'd0, 2'b00, 5'd1,  1'b0, 1'b1, 32'h80000001, 32'h0,        32'h00000002, 1'b1, 1);
        vecs[7]  = mk(1'b0, 8'h00, 4'd0, 2'b00, 5'd0,  1'b0, 1'b0, 32'h12345678, 32'h0,        32'h12345678, 1'b0, 1);
        vecs[8]  = mk(1'b0, 8'h00, 4'd0, 2'b01, 5'd4,  1'b0, 1'b0, 32'h12345678, 32'h0,        32'h01234567, 1'b1, 1);
        vecs[9]  = mk(1'b0, 8'h00, 4'd0, 2'b10, 5'd4,  1'b0, 1'b1, 32'h80000010, 32'h0,        32'hF8000001, 1'b0, 1);
        vecs[10] = mk(1'b0, 8'h00, 4'd0, 2'b11, 5'd8,  1'b0, 1'b1, 32'h12345678, 32'h0,        32'h78123456, 1'b0, 1);
        vecs[11] = mk(1'b0, 8'h00, 4'd0, 2'b00, 5'd0,  1'b1, 1'b1, 32'h00000003, 32'h00000021, 32'h00000000, 1'b0, 2);
        vecs[12] = mk(1'b0, 8'h00, 4'd0, 2'b01, 5'd0,  1'b1, 1'b0, 32'h80000000, 32'h00000120, 32'h00000000, 1'b1, 2);
        vecs[13] = mk(1'b0, 8'h00, 4'd0, 2'b10, 5'd0,  1'b1, 1'b0, 32'h80000000, 32'h00000100, 32'h80000000, 1'b0, 2);
        vecs[14] = mk(1'b0, 8'h00, 4'd0, 2'b11, 5'd0,  1'b1, 1'b1, 32'h12345678, 32'h00000100, 32'h12345678, 1'b1, 2);
        vecs[15] = mk(1'b0, 8'h00, 4'd0, 2'b11, 5'd0,  1'b1, 1'b0, 32'h12345678, 32'h00000010, 32'h56781234, 1'b0, 2);
        vecs[16] = mk(1'b0, 8'h00, 4'd0, 2'b11, 5'd0,  1'b1, 1'b0, 32'h80000000, 32'h00000040, 32'h80000000, 1'b1, 2);
        vecs[17] = mk(1'b0, 8'h00, 4'd0, 2'b10, 5'd0,  1'b1, 1'b0, 32'h80000000, 32'hFFFFFF28, 32'hFFFFFFFF, 1'b1, 2);
        vecs[18] = mk(1'b0, 8'h00, 4'd0, 2'b00, 5'd0,  1'b1, 1'b0, 32'hF0000001, 32'h00000004, 32'h00000010, 1'b1, 2);

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_Valid}, 32'd0);
        chk("rst_op2", out_Op2, 32'd0);
        chk("rst_carry", {31'd0, out_Carry}, 32'd0);
        chk("rst_rn", out_Rn, 32'd0);
        chk("rst_opcode", {28'd0, out_Opcode}, 32'd0);
        chk("rst_ready", {31'd0, out_Ready}, 32'd1);
        @(negedge in_Clk);
        in_Rst_N = 1'b1;
        @(posedge in_Clk); #1;

        // Vector table
        for (int i = 0; i < 19; i++) begin
            int lat;
            in_ImmMode = vecs[i].imm_mode; in_Imm8 = vecs[i].imm8; in_Rot = vecs[i].rot;
            in_ShiftType = vecs[i].stype; in_ShiftImm = vecs[i].simm;
            in_ShiftByReg = vecs[i].by_reg; in_CFlag = vecs[i].cflag;
            in_Rm = vecs[i].rm; in_Rs = vecs[i].rs;
            in_Rn = 32'hA0000000 + i; in_Opcode = i[3:0];
            in_Ready = 1'b1; in_Valid = 1'b1;
            chk($sformatf("v%0d_ready", i), {31'd0, out_Ready}, 32'd1);
            @(posedge in_Clk); #1;
            in_Valid = 1'b0;
            in_Rm = 32'hDEADBEEF; in_Rs = 32'hDEADBEEF; in_CFlag = ~vecs[i].cflag;
            lat = 1;
            while (!out_Valid && lat < 5) begin
                chk($sformatf("v%0d_busy_ready", i), {31'd0, out_Ready}, 32'd0);
                @(posedge in_Clk); #1;
                lat++;
            end
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_op2", i), out_Op2, vecs[i].exp_op2);
            chk($sformatf("v%0d_carry", i), {31'd0, out_Carry}, {31'd0, vecs[i].exp_c});
            chk($sformatf("v%0d_rn", i), out_Rn, 32'hA0000000 + i);
            chk($sformatf("v%0d_opc", i), {28'd0, out_Opcode}, {28'd0, i[3:0]});
        end
        @(posedge in_Clk); #1;
        chk("idle_valid", {31'd0, out_Valid}, 32'd0);

        // Backpressure: A held 3 cycles while B waits, B accepted when ready rises
        in_Ready = 1'b0;
        drive_imm(8'h12, 4'd0, 32'h0000AAAA, 4'd5);
        in_Valid = 1'b1;
        chk("bp_ready_a", {31'd0, out_Ready}, 32'd1);
        @(posedge in_Clk); #1;
        drive_imm(8'h34, 4'd0, 32'h0000BBBB, 4'd6);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", {31'd0, out_Valid}, 32'd1);
            chk("bp_hold_op2", out_Op2, 32'h00000012);
            chk("bp_hold_rn", out_Rn, 32'h0000AAAA);
            chk("bp_hold_opc", {28'd0, out_Opcode}, 32'd5);
            chk("bp_hold_ready", {31'd0, out_Ready}, 32'd0);
            @(posedge in_Clk); #1;
        end
        chk("bp_still_a", out_Op2, 32'h00000012);
        in_Ready = 1'b1;
        #1;
        chk("bp_ready_rise", {31'd0, out_Ready}, 32'd1);
        @(posedge in_Clk); #1;
        in_Valid = 1'b0;
        chk("bp_b_valid", {31'd0, out_Valid}, 32'd1);
        chk("bp_b_op2", out_Op2, 32'h00000034);
        chk("bp_b_rn", out_Rn, 32'h0000BBBB);
        chk("bp_b_opc", {28'd0, out_Opcode}, 32'd6);
        @(posedge in_Clk); #1;
        chk("bp_drain", {31'd0, out_Valid}, 32'd0);

        // Streaming: 8 bundles, one result per cycle in order
        for (int k = 0; k < 8; k++) begin
            drive_imm(8'(k + 1), 4'd0, 32'h0000C000 + k, 4'(k));
            in_Valid = 1'b1;
            @(posedge in_Clk); #1;
            chk($sformatf("st%0d_valid", k), {31'd0, out_Valid}, 32'd1);
            chk($sformatf("st%0d_op2", k), out_Op2, 32'(k + 1));
            chk($sformatf("st%0d_rn", k), out_Rn, 32'h0000C000 + k);
        end
        in_Valid = 1'b0;
        @(posedge in_Clk); #1;
        chk("st_drain", {31'd0, out_Valid}, 32'd0);

        // Reset while a register-amount shift sits in REG
        in_ImmMode = 1'b0; in_ShiftByReg = 1'b1; in_ShiftType = 2'b00;
        in_Rm = 32'h00000001; in_Rs = 32'h00000004; in_Rn = 32'h0000DDDD; in_Opcode = 4'd9;
        in_Valid = 1'b1;
        @(posedge in_Clk); #1;
        in_Valid = 1'b0;
        chk("rr_in_reg", {31'd0, out_Ready}, 32'd0);
        #1;
        in_Rst_N = 1'b0;
        #1;
        chk("rr_valid", {31'd0, out_Valid}, 32'd0);
        chk("rr_op2", out_Op2, 32'd0);
        @(negedge in_Clk);
        in_Rst_N = 1'b1;
        @(posedge in_Clk); #1;
        chk("rr_ready", {31'd0, out_Ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("rr_no_ghost", {31'd0, out_Valid}, 32'd0);
            @(posedge in_Clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
